// File: rtl/awg_pkg.sv
// Shared definitions for the AWG datapath: default sample width and the
// slope-detector state encoding used by wave_meas.
package awg_pkg;

  localparam int DW_DEF = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    RISE = 2'd2
  } wm_state_t;

endpackage

// File: rtl/wm_slope_det.sv
// Slope detector with hysteresis: follows the running extreme of the current
// slope and flags a valley when the signal climbs more than HYST above it.
module wm_slope_det
  import awg_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int HYST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [DW-1:0] i_sample,
  output logic          o_valley,
  output wm_state_t     o_state
);

  localparam logic [DW:0] HYST_W = (DW+1)'(HYST);

  wm_state_t   r_state;
  wm_state_t   w_next_state;
  logic [DW-1:0] r_ext;
  logic [DW-1:0] w_next_ext;
  logic [DW:0] w_s;
  logic [DW:0] w_e;
  logic        w_climb;
  logic        w_drop;

  // One extra bit keeps the hysteresis sums from wrapping near full scale.
  assign w_s     = {1'b0, i_sample};
  assign w_e     = {1'b0, r_ext};
  assign w_climb = w_s > (w_e + HYST_W);
  assign w_drop  = (w_s + HYST_W) < w_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ext   <= '0;
    end else begin
      r_state <= w_next_state;
      r_ext   <= w_next_ext;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_ext   = r_ext;
    if (i_en) begin
      case (r_state)
        IDLE: begin
          w_next_ext   = i_sample;
          w_next_state = FALL;
        end
        FALL: begin
          if (w_climb) begin
            w_next_ext   = i_sample;
            w_next_state = RISE;
          end else if (i_sample < r_ext) begin
            w_next_ext = i_sample;
          end
        end
        RISE: begin
          if (w_drop) begin
            w_next_ext   = i_sample;
            w_next_state = FALL;
          end else if (i_sample > r_ext) begin
            w_next_ext = i_sample;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    o_valley = i_en && (r_state == FALL) && w_climb;
  end

  assign o_state = r_state;

endmodule

// File: rtl/wave_meas.sv
// Waveform measurement: counts enabled samples between valleys and tracks the
// run extremes, publishing period/max/min/peak-to-peak once per full cycle.
module wave_meas
  import awg_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int CW   = 24,
  parameter int HYST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] sample_in,
  output logic [CW-1:0] period_out,
  output logic [DW-1:0] max_out,
  output logic [DW-1:0] min_out,
  output logic [DW-1:0] pp_out,
  output logic          meas_valid,
  output logic          ovf
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  wm_state_t     w_state;
  logic          w_valley;
  logic [CW-1:0] r_cnt;
  logic          r_sat;
  logic          r_armed;
  logic [DW-1:0] r_run_max;
  logic [DW-1:0] r_run_min;
  logic [CW-1:0] r_period;
  logic [DW-1:0] r_max;
  logic [DW-1:0] r_min;
  logic [DW-1:0] r_pp;
  logic          r_valid;
  logic          r_ovf;

  wm_slope_det #(
    .DW  (DW),
    .HYST(HYST)
  ) u_slope (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (en),
    .i_sample(sample_in),
    .o_valley(w_valley),
    .o_state (w_state)
  );

  // The triggering sample opens the new run; the publish uses pre-event values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_armed   <= 1'b0;
      r_run_max <= '0;
      r_run_min <= '0;
      r_period  <= '0;
      r_max     <= '0;
      r_min     <= '0;
      r_pp      <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (en) begin
        if ((w_state == IDLE) || w_valley) begin
          r_run_max <= sample_in;
          r_run_min <= sample_in;
          r_cnt     <= CW'(1);
          r_sat     <= 1'b0;
          if (w_valley) begin
            r_armed <= 1'b1;
            if (r_armed) begin
              r_period <= r_cnt;
              r_max    <= r_run_max;
              r_min    <= r_run_min;
              r_pp     <= r_run_max - r_run_min;
              r_ovf    <= r_sat;
              r_valid  <= 1'b1;
            end
          end
        end else begin
          if (sample_in > r_run_max) r_run_max <= sample_in;
          if (sample_in < r_run_min) r_run_min <= sample_in;
          if (r_cnt == CNT_MAX) r_sat <= 1'b1;
          else r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign period_out = r_period;
  assign max_out    = r_max;
  assign min_out    = r_min;
  assign pp_out     = r_pp;
  assign meas_valid = r_valid;
  assign ovf        = r_ovf;

endmodule
